add_serial_feed: RTL and testbench

Operand sequencer placed directly upstream of `add_serial`. It buffers operand pairs from a valid/ready source in a small FIFO and drives them one at a time into the serial adder, pulsing its `en` for one cycle. After a fixed adder latency it captures the adder's `out` and presents it to the consumer through a valid/ready result port. The serial adder has no handshake of its own, so this block is its only source of operands and its only means of flow control.

---
 rtl/add_serial_feed.sv | 251 +++++++++++++++++++++++++
 tb/tb_add_serial_feed.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_feed.sv
// ---------------------------------------------------------------------------
// add_serial_feed
//
// Operand sequencer that sits directly in front of the add_serial serial
// adder. Operand pairs arrive on a valid/ready port and are buffered in a
// small circular FIFO. One pair at a time is popped into a holding register,
// driven onto the adder inputs and started with a single-cycle add_en pulse.
// After a fixed adder latency the adder output is captured and offered to the
// consumer on a valid/ready result port. The adder has no handshake of its
// own, so this block is its only source of operands and of flow control.
//
// Parameters:
//   WIDTH  operand and sum width (must match the serial adder)
//   DEPTH  operand FIFO entries, power of two, at least 2
//   LAT    clock edges from the edge that samples add_en high to the edge
//          that samples add_out, at least 1
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  FIFO can accept a pair (not full)
//   in_a       in   operand A
//   in_b       in   operand B
//   add_en     out  start pulse to the serial adder
//   add_a      out  operand A to the serial adder
//   add_b      out  operand B to the serial adder
//   add_out    in   sum from the serial adder
//   res_valid  out  captured result is valid and held
//   res_ready  in   consumer accepts the result
//   res_sum    out  captured sum
//   busy       out  an operation is in flight or operands are queued
//   err        out  sticky adder check mismatch flag
//
// Build option:
//   ADD_SERIAL_FEED_CHECK_EN  when defined, every captured add_out is compared
//                             against a locally computed sum and a mismatch
//                             sets err until reset. When undefined, no
//                             comparator exists and err is tied low.
// ---------------------------------------------------------------------------
module add_serial_feed #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             busy,
    output logic             err
);

    // Address width of the FIFO storage; pointers carry one extra wrap bit so
    // that full and empty can be told apart without a separate counter.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // The timer counts up to LAT in WAIT, so it needs room for LAT itself.
    localparam int TW = $clog2(LAT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TW-1:0]    timer;
    logic             capture;
    logic             release_res;
    logic             issue;

    // FIFO status. Empty when the pointers are identical; full when the
    // addresses match but the wrap bits differ. A full FIFO refuses a push
    // even if the sequencer pops in the same cycle, because there is no
    // bypass path from the input to the holding register.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;

    // FIFO storage. The array itself is not reset: its contents are only
    // ever read between the write and read pointers, and those are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]] <= in_a;
            mem_b[wr_ptr[AW-1:0]] <= in_b;
        end
    end

    // FIFO pointers. Push and pop are independent, so a pop in the same
    // cycle as a push on a partially filled FIFO simply moves both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Sequencer state register. Reset drops straight back to IDLE, which
    // also removes add_en asynchronously since it decodes from the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next-state and control decode. IDLE pops the FIFO head as
    // soon as one is available, ISSUE is the one-cycle start pulse, WAIT
    // runs the latency timer down to the capture edge, and HOLD keeps the
    // result on the port until the consumer takes it.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        issue       = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (timer == TIMER_LAST) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    release_res = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign add_en = issue;
    assign busy   = (state != IDLE) || !fifo_empty;

    // Operand holding register. Loaded only on a pop, so the adder inputs
    // stay stable from ISSUE all the way through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (pop) begin
            op_a <= mem_a[rd_ptr[AW-1:0]];
            op_b <= mem_b[rd_ptr[AW-1:0]];
        end
    end

    assign add_a = op_a;
    assign add_b = op_b;

    // Latency timer. Cleared on the ISSUE edge, then advanced once per WAIT
    // cycle; the capture happens on the edge that sees LAT-1, which is LAT
    // edges after the edge that sampled add_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + TW'(1);
        end
    end

    // Result register. The sum is taken straight from the adder so that
    // the consumer always sees what the adder produced, and it is held
    // unchanged until the handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_sum   <= add_out;
        end else if (release_res) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ADD_SERIAL_FEED_CHECK_EN
    logic [WIDTH-1:0] local_sum;
    logic             err_q;

    // Reference sum from the held operands, wrapping modulo 2^WIDTH just
    // like the adder does.
    assign local_sum = op_a + op_b;

    // Sticky checker. A disagreement on any capture edge latches err, and
    // only reset can clear it, so a single bad result is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (capture && (add_out != local_sum)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_add_serial_feed.sv
// ---------------------------------------------------------------------------
// tb_add_serial_feed
//
// Self-checking bench for add_serial_feed with default parameters
// (WIDTH=8, DEPTH=4, LAT=10). A behavioural serial adder registers a+b when
// it sees en, and deliberately corrupts bit 0 for the pair 0x10/0x20 so the
// optional checker can be exercised. Expected sums are pushed to a
// scoreboard queue when a pair is accepted and popped when a result is
// handed over on the result port.
// ---------------------------------------------------------------------------
module tb_add_serial_feed;

    localparam int WIDTH = 8;
    localparam int LAT   = 10;

`ifdef ADD_SERIAL_FEED_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             add_en;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             busy;
    logic             err;

    int               n_compared   = 0;
    int               n_mismatched = 0;
    int               en_pulses    = 0;
    int               valid_samples = 0;
    logic [WIDTH-1:0] sb [$];

    add_serial_feed #(
        .WIDTH (WIDTH),
        .DEPTH (4),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the serial adder model produces: a modulo-256 sum, with bit 0
    // flipped for the one pair used to provoke the checker.
    function automatic logic [WIDTH-1:0] modelSum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        s = a + b;
        if (a == 8'h10 && b == 8'h20) begin
            s = s ^ 8'h01;
        end
        return s;
    endfunction

    // Behavioural serial adder: result appears after the en edge and stays
    // put until the next start, so it is valid on the capture edge.
    logic [WIDTH-1:0] adder_q = '0;
    always @(posedge clk) begin
        if (add_en) begin
            adder_q <= modelSum(add_a, add_b);
        end
    end
    assign add_out = adder_q;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Output monitor: counts start pulses and valid cycles, and on every
    // completed result handshake pops the scoreboard and compares the sum.
    always @(negedge clk) begin
        if (!rst) begin
            if (add_en) en_pulses++;
            if (res_valid) valid_samples++;
            if (res_valid && res_ready) begin
                checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    checkOutput("res_sum", 32'(res_sum), 32'(sb.pop_front()));
                end
            end
        end
    end

    // Drive one pair for one cycle; the scoreboard learns about it only if
    // the FIFO was ready on the sampling edge. Called and returns at
    // posedge+1.
    task automatic applyStimulus(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 output logic accepted);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        accepted = in_ready;
        if (accepted) sb.push_back(modelSum(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait, with a cycle budget, until the block is idle and nothing is
    // pending on the result port; returns realigned at posedge+1.
    task automatic waitIdle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy && !res_valid) done = 1'b1;
        end
        checkOutput(tag, 32'(done), 32'd1);
        checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        int   en_first;
        int   en_count;
        int   valid_first;
        int   en_snap;
        int   valid_snap;
        logic [WIDTH-1:0] first_exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_add_en",    32'(add_en),    32'd0);
        checkOutput("rst_add_a",     32'(add_a),     32'd0);
        checkOutput("rst_add_b",     32'(add_b),     32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_sum",   32'(res_sum),   32'd0);
        checkOutput("rst_err",       32'(err),       32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        rst       = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single pair: start pulse on cycle 1 only, result on cycle 12
        $display("[TB] single pair latency");
        applyStimulus(8'h35, 8'h4A, acc);
        checkOutput("single_accept", 32'(acc), 32'd1);
        en_first = -1;
        en_count = 0;
        valid_first = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (add_en) begin
                en_count++;
                if (en_first < 0) en_first = k - 1;
            end
            if (res_valid && valid_first < 0) valid_first = k - 1;
        end
        checkOutput("en_cycle",    32'(en_first),    32'd1);
        checkOutput("en_count",    32'(en_count),    32'd1);
        checkOutput("valid_cycle", 32'(valid_first), 32'(LAT + 2));
        waitIdle("single_drain");

        // Wrap-around sum with a correct adder result
        $display("[TB] wrap-around");
        applyStimulus(8'hFF, 8'h01, acc);
        checkOutput("wrap_accept", 32'(acc), 32'd1);
        waitIdle("wrap_drain");
        checkOutput("wrap_err", 32'(err), 32'd0);

        // Back-pressure: result held, FIFO fills, sixth push refused
        $display("[TB] back-pressure");
        res_ready = 1'b0;
        en_snap   = en_pulses;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(8'h40 + i);
            in_b     = 8'(3 * i + 1);
            acc      = in_ready;
            if (acc) sb.push_back(modelSum(in_a, in_b));
            checkOutput($sformatf("bp_accept%0d", i), 32'(acc), 32'(i < 5));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        first_exp = sb[0];
        checkOutput("bp_en_pulses", 32'(en_pulses - en_snap), 32'd1);
        checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
        checkOutput("bp_res_sum",   32'(res_sum),   32'(first_exp));
        checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
        res_ready = 1'b1;
        waitIdle("bp_drain");
        checkOutput("bp_total_en", 32'(en_pulses - en_snap), 32'd5);

        // Reset in the middle of WAIT with two pairs still queued
        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(8'h21 + i);
            in_b     = 8'(8'h05 + i);
            acc      = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        checkOutput("mid_rst_add_en",    32'(add_en),    32'd0);
        checkOutput("mid_rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_busy",      32'(busy),      32'd0);
        checkOutput("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        en_snap    = en_pulses;
        valid_snap = valid_samples;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("post_rst_no_en",    32'(en_pulses - en_snap),        32'd0);
        checkOutput("post_rst_no_valid", 32'(valid_samples - valid_snap), 32'd0);
        checkOutput("post_rst_busy",     32'(busy),                       32'd0);

        // Checker: adder returns a corrupted sum for 0x10 + 0x20
        $display("[TB] checker");
        applyStimulus(8'h10, 8'h20, acc);
        checkOutput("chk_accept", 32'(acc), 32'd1);
        waitIdle("chk_drain");
        checkOutput("chk_err", 32'(err), 32'(EXP_ERR));
        applyStimulus(8'h02, 8'h03, acc);
        waitIdle("chk_drain2");
        checkOutput("chk_err_sticky", 32'(err), 32'(EXP_ERR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
